// File: rtl/firmware_ram_pkg.sv
// Shared constants and helpers for the firmware on-chip RAM and its arbiter.
package firmware_ram_pkg;

    // Port identifiers used for arbitration history and read-pipeline tags.
    localparam logic PORT_S1 = 1'b0;
    localparam logic PORT_S2 = 1'b1;

    localparam int BYTE_W = 8;

    // Byte-lane count for a given data width (data width is a multiple of 8).
    function automatic int be_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Only a bare RAM read (1) or RAM read plus output register (2) exist.
    function automatic bit read_latency_ok(input int read_latency);
        return (read_latency == 1) || (read_latency == 2);
    endfunction

endpackage

// File: rtl/firmware_ram_core.sv
// Single-port byte-enabled RAM with a registered read and an optional
// output register. The array and the read registers hold while en is low.
module firmware_ram_core
    import firmware_ram_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 51200,
    parameter int    ADDR_W    = 16,
    parameter bit    OUT_REG   = 1'b0,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                we,
    input  logic                re,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] dout_q;

    // The init-file attribute is only attached when a file is named, so an
    // empty string leaves the array uninitialised.
    if (INIT_FILE != "") begin : g_init
        (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem_q [DEPTH];

        // Byte-lane writes and registered read of the shared array.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    for (int i = 0; i < BE_W; i++) begin
                        if (be[i]) mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                    end
                end
                if (re) ram_q <= mem_q[addr];
            end
        end
    end else begin : g_noinit
        logic [DATA_W-1:0] mem_q [DEPTH];

        // Byte-lane writes and registered read of the shared array.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    for (int i = 0; i < BE_W; i++) begin
                        if (be[i]) mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                    end
                end
                if (re) ram_q <= mem_q[addr];
            end
        end
    end

    // Output register for the two-cycle latency build; clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     dout_q <= '0;
        else if (en) dout_q <= ram_q;
    end

    assign rdata = OUT_REG ? dout_q : ram_q;

endmodule

// File: rtl/firmware_onchip_ram_arb.sv
// Two Avalon-MM slave ports sharing one single-port RAM through a
// round-robin arbiter, with a port-tagged read pipeline feeding
// readdatavalid back to the port that issued each read.
module firmware_onchip_ram_arb
    import firmware_ram_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 51200,
    parameter int    ADDR_W       = 16,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_ram.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic                reset_req,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest
);

    localparam int RL = READ_LATENCY;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    logic                en;
    logic                req1, req2;
    logic                gnt1, gnt2, gnt_any;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   sel_addr, core_addr;
    logic                sel_read, sel_write, in_range;
    logic [DATA_W/8-1:0] sel_be;
    logic [DATA_W-1:0]   sel_wdata, core_rdata, rdata_out;
    logic                core_we, rd_go;
    logic [RL-1:0]       vld_q, port_q, oor_q;
    logic [1:0]          rdv;

    assign en   = clken & ~reset_req;
    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    // Round-robin grant: on a tie the port not granted most recently wins.
    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (en && !freeze) begin
            if (req1 && req2) begin
                if (last_grant_q == PORT_S2) gnt1 = 1'b1;
                else                         gnt2 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end else if (req2) begin
                gnt2 = 1'b1;
            end
        end
    end

    assign gnt_any        = gnt1 | gnt2;
    assign s1_waitrequest = req1 & ~gnt1;
    assign s2_waitrequest = req2 & ~gnt2;

    // Steer the granted port's request onto the RAM; write wins over read.
    assign sel_addr  = gnt2 ? s2_address    : s1_address;
    assign sel_read  = gnt2 ? s2_read       : s1_read;
    assign sel_write = gnt2 ? s2_write      : s1_write;
    assign sel_be    = gnt2 ? s2_byteenable : s1_byteenable;
    assign sel_wdata = gnt2 ? s2_writedata  : s1_writedata;
    assign in_range  = ({1'b0, sel_addr} < DEPTH_W);
    assign core_addr = in_range ? sel_addr : '0;
    assign core_we   = gnt_any & sel_write & in_range;
    assign rd_go     = gnt_any & sel_read & ~sel_write;

    assign last_grant_d = gnt1 ? PORT_S1 : (gnt2 ? PORT_S2 : last_grant_q);

    // Arbitration history; reset leaves s2 as last so s1 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   last_grant_q <= PORT_S2;
        else if (en) last_grant_q <= last_grant_d;
    end

    // Read pipeline carrying valid, port tag and out-of-range flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            port_q <= '0;
            oor_q  <= '0;
        end else if (en) begin
            vld_q[0]  <= rd_go;
            port_q[0] <= gnt2;
            oor_q[0]  <= ~in_range;
            for (int i = 1; i < RL; i++) begin
                vld_q[i]  <= vld_q[i-1];
                port_q[i] <= port_q[i-1];
                oor_q[i]  <= oor_q[i-1];
            end
        end
    end

    firmware_ram_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .OUT_REG   (RL == 2),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk   (clk),
        .rst   (reset),
        .en    (en),
        .we    (core_we),
        .re    (rd_go),
        .be    (sel_be),
        .addr  (core_addr),
        .wdata (sel_wdata),
        .rdata (core_rdata)
    );

    // Out-of-range reads return zero on the normal strobe.
    assign rdata_out = oor_q[RL-1] ? '0 : core_rdata;

    // Strobe only the tagged port, and hold it off while the clock is disabled.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign rdv[gi] = en & vld_q[RL-1] & (port_q[RL-1] == 1'(gi));
    end

    assign s1_readdatavalid = rdv[0];
    assign s2_readdatavalid = rdv[1];
    assign s1_readdata      = rdata_out;
    assign s2_readdata      = rdata_out;

endmodule

// File: tb/tb_firmware_onchip_ram_arb.sv
// Scoreboard bench: a request-level master/arbiter/memory model predicts
// waitrequest and read responses; a negedge monitor checks the DUT.
module tb_firmware_onchip_ram_arb;

    localparam int DW    = 32;
    localparam int DEPTH = 51200;
    localparam int AW    = 16;
    localparam int RL    = 2;

    logic clk = 1'b0;
    logic reset, clken, reset_req, freeze;
    logic [AW-1:0] s1_address, s2_address;
    logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0] s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

    always #5 clk = ~clk;

    firmware_onchip_ram_arb #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(RL), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
    );

    typedef struct { bit idle; bit wr; int addr; logic [3:0] be; logic [31:0] data; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] mask; int unsigned due; } rsp_t;

    req_t        plan [2][$];
    req_t        cur  [2];
    bit          cur_v[2];
    rsp_t        rsq  [2][$];
    logic [31:0] mdat [int];
    logic [31:0] mmask[int];
    int          last_m;
    int unsigned ecnt;
    bit          exp_wait[2];
    int          errors = 0;
    int          checks = 0;

    function automatic req_t mk(bit idle, bit wr, int addr, logic [3:0] be, logic [31:0] d);
        req_t r;
        r.idle = idle; r.wr = wr; r.addr = addr; r.be = be; r.data = d;
        return r;
    endfunction

    task automatic drive(input int p, input bit act, input req_t r);
        if (p == 0) begin
            s1_chipselect = act; s1_read = act & ~r.wr; s1_write = act & r.wr;
            s1_address = AW'(r.addr); s1_byteenable = r.be; s1_writedata = r.data;
        end else begin
            s2_chipselect = act; s2_read = act & ~r.wr; s2_write = act & r.wr;
            s2_address = AW'(r.addr); s2_byteenable = r.be; s2_writedata = r.data;
        end
    endtask

    // One bus cycle: masters present requests, model arbitrates and applies.
    task automatic step();
        bit g[2];
        bit en;
        int w;
        for (int p = 0; p < 2; p++) begin
            if (!cur_v[p] && plan[p].size() > 0) begin
                req_t r;
                r = plan[p].pop_front();
                if (!r.idle) begin cur[p] = r; cur_v[p] = 1'b1; end
            end
            drive(p, cur_v[p], cur[p]);
        end
        en = clken & ~reset_req;
        g[0] = 1'b0; g[1] = 1'b0;
        if (en && !freeze) begin
            if (cur_v[0] && cur_v[1]) begin
                w = (last_m == 1) ? 0 : 1;
                g[w] = 1'b1;
            end else if (cur_v[0]) g[0] = 1'b1;
            else if (cur_v[1]) g[1] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            exp_wait[p] = cur_v[p] & ~g[p];
            if (g[p]) begin
                req_t r;
                r = cur[p];
                if (r.wr) begin
                    if (r.addr < DEPTH) begin
                        logic [31:0] d, m;
                        d = mdat.exists(r.addr) ? mdat[r.addr] : 32'h0;
                        m = mmask.exists(r.addr) ? mmask[r.addr] : 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (r.be[b]) begin
                                d[b*8 +: 8] = r.data[b*8 +: 8];
                                m[b*8 +: 8] = 8'hFF;
                            end
                        end
                        mdat[r.addr] = d; mmask[r.addr] = m;
                    end
                end else begin
                    rsp_t s;
                    s.due = ecnt + RL;
                    if (r.addr >= DEPTH) begin s.data = 32'h0; s.mask = 32'hFFFF_FFFF; end
                    else if (mdat.exists(r.addr)) begin s.data = mdat[r.addr]; s.mask = mmask[r.addr]; end
                    else begin s.data = 32'h0; s.mask = 32'h0; end
                    rsq[p].push_back(s);
                end
                last_m = p;
                cur_v[p] = 1'b0;
            end
        end
        @(posedge clk);
        if (en) ecnt++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        rsq[0].delete(); rsq[1].delete();
        cur_v[0] = 1'b0; cur_v[1] = 1'b0;
        last_m = 1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((plan[0].size() + plan[1].size() + rsq[0].size() + rsq[1].size() > 0 ||
                cur_v[0] || cur_v[1]) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_%s: still busy after %0d cycles (q1=%0d q2=%0d)",
                     name, n, rsq[0].size(), rsq[1].size());
            rsq[0].delete(); rsq[1].delete(); plan[0].delete(); plan[1].delete();
            cur_v[0] = 1'b0; cur_v[1] = 1'b0;
        end
    endtask

    // Monitor: compare waitrequest and pop/compare read responses.
    always @(negedge clk) begin : mon
        bit aw, av, ev;
        logic [31:0] ad;
        rsp_t s;
        for (int p = 0; p < 2; p++) begin
            aw = (p == 0) ? s1_waitrequest : s2_waitrequest;
            av = (p == 0) ? s1_readdatavalid : s2_readdatavalid;
            ad = (p == 0) ? s1_readdata : s2_readdata;
            checks++;
            if (aw !== exp_wait[p]) begin
                errors++;
                $display("FAIL waitrequest_s%0d @%0t: got %b expected %b", p+1, $time, aw, exp_wait[p]);
            end
            ev = (clken & ~reset_req) && rsq[p].size() > 0 && rsq[p][0].due == ecnt;
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL readdatavalid_s%0d @%0t: got %b expected %b", p+1, $time, av, ev);
            end
            if (ev) begin
                s = rsq[p].pop_front();
                if (av && s.mask != 0) begin
                    checks++;
                    if ((ad & s.mask) !== (s.data & s.mask)) begin
                        errors++;
                        $display("FAIL readdata_s%0d @%0t: got %h expected %h (mask %h)",
                                 p+1, $time, ad, s.data, s.mask);
                    end
                end
            end
        end
    end

    initial begin
        int a;
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
        cur_v[0] = 1'b0; cur_v[1] = 1'b0; exp_wait[0] = 1'b0; exp_wait[1] = 1'b0;
        last_m = 1; ecnt = 0;
        drive(0, 1'b0, mk(1, 0, 0, 0, 0));
        drive(1, 1'b0, mk(1, 0, 0, 0, 0));
        do_reset(3);

        // Single write then read on s1.
        plan[0].push_back(mk(0, 1, 'h10, 4'hF, 32'hDEADBEEF));
        plan[0].push_back(mk(0, 0, 'h10, 4'h0, 0));
        drain("single");

        // Byte enables, including an all-zero byteenable write.
        plan[0].push_back(mk(0, 1, 'h20, 4'hF, 32'h11223344));
        plan[0].push_back(mk(0, 1, 'h20, 4'h5, 32'hAABBCCDD));
        plan[0].push_back(mk(0, 1, 'h20, 4'h0, 32'hFFFFFFFF));
        plan[0].push_back(mk(0, 0, 'h20, 4'h0, 0));
        drain("byteen");

        // Preload, then contention right after a reset: s1 first, then alternate.
        for (int i = 0; i < 8; i++) plan[1].push_back(mk(0, 1, i, 4'hF, $urandom));
        drain("preload");
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            plan[0].push_back(mk(0, 0, i, 0, 0));
            plan[1].push_back(mk(0, 0, 7 - i, 0, 0));
        end
        drain("contention");

        // Range boundary.
        plan[0].push_back(mk(0, 1, DEPTH - 1, 4'hF, 32'hCAFEF00D));
        plan[0].push_back(mk(0, 0, DEPTH - 1, 0, 0));
        plan[0].push_back(mk(0, 0, DEPTH, 0, 0));
        plan[0].push_back(mk(0, 1, DEPTH, 4'hF, 32'h55AA55AA));
        plan[0].push_back(mk(0, 0, 0, 0, 0));
        drain("range");

        // Freeze while a read is in flight.
        plan[0].push_back(mk(0, 0, 3, 0, 0));
        step();
        freeze = 1'b1;
        plan[0].push_back(mk(0, 0, 4, 0, 0));
        plan[1].push_back(mk(0, 0, 5, 0, 0));
        for (int i = 0; i < 4; i++) step();
        freeze = 1'b0;
        drain("freeze");

        // Clock enable low for 3 cycles, then reset_req for 2, mid-read.
        plan[0].push_back(mk(0, 0, 1, 0, 0));
        step();
        clken = 1'b0;
        plan[1].push_back(mk(0, 1, 6, 4'h3, 32'h0BADCAFE));
        for (int i = 0; i < 3; i++) step();
        clken = 1'b1;
        drain("clken");
        plan[1].push_back(mk(0, 0, 2, 0, 0));
        step();
        reset_req = 1'b1;
        for (int i = 0; i < 2; i++) step();
        reset_req = 1'b0;
        plan[0].push_back(mk(0, 0, 6, 0, 0));
        drain("reset_req");

        // Reset one cycle after a read grant; memory must survive.
        plan[1].push_back(mk(0, 0, 'h10, 0, 0));
        step();
        do_reset(2);
        plan[0].push_back(mk(0, 0, 'h10, 0, 0));
        plan[1].push_back(mk(0, 0, 'h20, 0, 0));
        drain("reset_mid");

        // Randomised traffic with random stalls.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!cur_v[p] && plan[p].size() == 0) begin
                    int k;
                    k = $urandom_range(0, 9);
                    a = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH - 6, DEPTH + 6)
                                                    : $urandom_range(0, 15);
                    if (k < 3) plan[p].push_back(mk(1, 0, 0, 0, 0));
                    else if (k < 6) plan[p].push_back(mk(0, 1, a, 4'($urandom), $urandom));
                    else plan[p].push_back(mk(0, 0, a, 0, 0));
                end
            end
            freeze    = ($urandom_range(0, 9) == 0);
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            step();
        end
        freeze = 1'b0; clken = 1'b1; reset_req = 1'b0;
        drain("random");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/firmware_onchip_ram_arb.md
Name: firmware_onchip_ram_arb

Overview:
- Parametrised on-chip RAM with two Avalon-MM slave ports (s1, s2) sharing one single-port memory array.
- Round-robin arbiter, waitrequest back-pressure, pipelined reads with readdatavalid, and selectable read latency.
- Sits on the Qsys fabric as the firmware/data memory. s1 is typically the CPU instruction master and s2 the data master or DMA.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 51200, number of words; need not be a power of two.
- ADDR_W, 16, word-address width; 2**ADDR_W >= DEPTH.
- READ_LATENCY, 1, cycles from grant to readdatavalid; legal values 1 or 2 (2 = registered output).
- INIT_FILE, "onchip_ram.hex", memory initialisation file; an empty string means no initialisation.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  global clock enable.
- reset_req  in  1  reset request; blocks access like clken=0.
- freeze  in  1  stop new grants; in-flight reads drain.
- s1_address  in  ADDR_W  word address.
- s1_chipselect  in  1  port select.
- s1_read  in  1  read request.
- s1_write  in  1  write request.
- s1_byteenable  in  DATA_W/8  byte lanes for writes.
- s1_writedata  in  DATA_W  write data.
- s1_readdata  out  DATA_W  read data.
- s1_readdatavalid  out  1  one-cycle read-data strobe.
- s1_waitrequest  out  1  request not accepted this cycle.
- s2_*  same set as s1_*.

Behaviour:
- Request definition: sN_req = sN_chipselect & (sN_read | sN_write). read and write both high is illegal; write wins.
- Definition: en = clken & ~reset_req.
- Grant rules, evaluated combinationally each cycle:
  - No grant while en=0 or freeze=1.
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted most recently wins; last_grant updates on every grant.
- sN_waitrequest = sN_req & ~grantN, combinational. The master holds its request stable while waitrequest is high.
- Write: commits at the clock edge of grant, byte lanes per byteenable. A write with byteenable=0 is granted but changes nothing.
- Read:
  - The granted address enters a READ_LATENCY-deep pipeline tagged with the port id.
  - sN_readdatavalid pulses exactly READ_LATENCY cycles after the grant edge, with sN_readdata valid in the same cycle.
  - Back-to-back grants sustain one read per cycle.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data. Read-during-write cannot occur (single access per cycle).
- Out-of-range address (>= DEPTH): write ignored; read returns 0 with normal readdatavalid timing.
- en=0: array, read pipeline and last_grant all hold. readdatavalid is forced low while held; a pending strobe resumes when en returns to 1, so no data is lost.
- freeze=1 with en=1: no new grants, but the pipeline advances and pending reads complete.
- Reset (asynchronous, at any time, including mid-read):
  - Pipeline cleared; pending reads are discarded and never signalled.
  - readdatavalid=0 on both ports.
  - readdata=0 when READ_LATENCY=2; when READ_LATENCY=1, readdata is don't-care while readdatavalid=0.
  - last_grant=s2, so s1 wins the first tie.
  - Memory contents are not cleared.
- Outputs are not gated by reset other than as listed above. waitrequest follows its combinational equation during reset.

Decomposition:
- Package firmware_ram_pkg:
  - Port-id constants PORT_S1=0 and PORT_S2=1.
  - Function checking READ_LATENCY legality.
  - Localparam BE_W = DATA_W/8.
- Sub-module firmware_ram_core:
  - Inferred single-port byte-enabled RAM (DATA_W, DEPTH, INIT_FILE, clock enable, optional output register).
  - The arbiter and pipeline tagging live in the top module.

Test Plan:
- Single write then read on s1: write 0xDEADBEEF to address 0x0010 with byteenable=0xF, read address 0x0010. Expect waitrequest=0 on both cycles, s1_readdatavalid READ_LATENCY cycles after the read grant, s1_readdata=0xDEADBEEF.
- Byte enables: preload 0x11223344, write 0xAABBCCDD with byteenable=0x5, then read. Expect 0x11BB33DD.
- Contention: s1 and s2 both issue continuous reads for 6 cycles, starting right after reset. Expect grants alternate s1,s2,s1,s2,s1,s2; each waitrequest is high on alternate cycles; every readdatavalid pulse carries the correct port's data.
- Range/latency: run with READ_LATENCY=2 and DEPTH=51200. A read of address 51199 returns the stored value two cycles after grant. A read of address 51200 returns 0; a write to 51200 leaves address 0 unchanged.
- Stalls:
  - freeze=1 while a read is in flight: that readdatavalid still fires; new requests see waitrequest=1 until freeze=0.
  - clken=0 for 3 cycles mid-read: readdatavalid is delayed by exactly 3 cycles and carries correct data.
- Reset mid-operation: assert reset one cycle after a read grant. Expect no readdatavalid for that read, memory intact, and s1 winning the first contention after reset.
